// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - host write/run bus of the systolic feeder
interface systolic_feeder_if #(
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic              wr_sel;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              start;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  wr_ready, busy, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output wr_ready, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - 3x3 weight/activation staging and skewed feed for the systolic array
// Optional weight reuse (skip LOAD_W when weights unchanged): SYSTOLIC_FEEDER_WEIGHT_REUSE_EN
module systolic_feeder #(
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  systolic_feeder_if.slave  host,
  output logic [DATA_W-1:0] west0,
  output logic [DATA_W-1:0] west3,
  output logic [DATA_W-1:0] west6,
  output logic [DATA_W-1:0] weight0,
  output logic [DATA_W-1:0] weight1,
  output logic [DATA_W-1:0] weight2,
  output logic [DATA_W-1:0] weight3,
  output logic [DATA_W-1:0] weight4,
  output logic [DATA_W-1:0] weight5,
  output logic [DATA_W-1:0] weight6,
  output logic [DATA_W-1:0] weight7,
  output logic [DATA_W-1:0] weight8,
  output logic              compute,
  output logic              weight_en
);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  localparam int             CNT_W       = 8;
  localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(4);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] act [9];
  logic [DATA_W-1:0] wgt [9];
  logic [DATA_W-1:0] act_fwd [9];
  logic [DATA_W-1:0] west0_nxt, west3_nxt, west6_nxt;
  logic              wr_accept;
  logic              load_needed;

  assign wr_accept = (state == IDLE) && host.wr_en && (host.wr_addr < 4'd9);

`ifdef SYSTOLIC_FEEDER_WEIGHT_REUSE_EN
  logic dirty;

  always_ff @(posedge clk) begin
    if (rst)
      dirty <= 1'b1;
    else if (wr_accept && host.wr_sel)
      dirty <= 1'b1;
    else if (state == LOAD_W)
      dirty <= 1'b0;
  end

  // A weight write landing on the start edge must still force a reload.
  assign load_needed = dirty || (wr_accept && host.wr_sel);
`else
  assign load_needed = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        act[i] <= '0;
        wgt[i] <= '0;
      end
    end else if (wr_accept) begin
      if (host.wr_sel)
        wgt[host.wr_addr] <= host.wr_data;
      else
        act[host.wr_addr] <= host.wr_data;
    end
  end

  // Bypass so a same-edge activation write reaches a run that skips LOAD_W.
  always_comb begin
    for (int i = 0; i < 9; i++)
      act_fwd[i] = (wr_accept && !host.wr_sel && host.wr_addr == 4'(i)) ? host.wr_data : act[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      west0 <= '0;
      west3 <= '0;
      west6 <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      west0 <= west0_nxt;
      west3 <= west3_nxt;
      west6 <= west6_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (host.start) state_nxt = load_needed ? LOAD_W : STREAM;
      LOAD_W:  state_nxt = STREAM;
      STREAM:  if (cnt == STREAM_LAST) state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
      DRAIN:   if (cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    cnt_nxt = (state_nxt == state && state_nxt != IDLE) ? cnt + CNT_W'(1) : '0;
  end

  // West values are computed one edge ahead so they line up with compute.
  always_comb begin
    west0_nxt = '0;
    west3_nxt = '0;
    west6_nxt = '0;
    if (state_nxt == STREAM) begin
      case (cnt_nxt)
        CNT_W'(0): west0_nxt = act_fwd[0];
        CNT_W'(1): begin west0_nxt = act_fwd[1]; west3_nxt = act_fwd[3]; end
        CNT_W'(2): begin west0_nxt = act_fwd[2]; west3_nxt = act_fwd[4]; west6_nxt = act_fwd[6]; end
        CNT_W'(3): begin west3_nxt = act_fwd[5]; west6_nxt = act_fwd[7]; end
        CNT_W'(4): west6_nxt = act_fwd[8];
        default: ;
      endcase
    end
  end

  always_comb begin
    weight_en     = (state == LOAD_W);
    compute       = (state == STREAM) || (state == DRAIN);
    host.done     = (state == DONE);
    host.busy     = (state != IDLE);
    host.wr_ready = (state == IDLE);
  end

  assign weight0 = wgt[0];
  assign weight1 = wgt[1];
  assign weight2 = wgt[2];
  assign weight3 = wgt[3];
  assign weight4 = wgt[4];
  assign weight5 = wgt[5];
  assign weight6 = wgt[6];
  assign weight7 = wgt[7];
  assign weight8 = wgt[8];
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream staging block for the 3x3 weight-stationary systolic array. It buffers one 3x3 weight tile and one 3x3 activation tile written by the host or controller. On `start`, it loads the weights into the array with a one-cycle `weight_en` pulse, then streams the activations into the three west inputs with the diagonal skew the array needs. It also drives the array's `compute` enable through a drain window and signals completion.

## Interface
Parameters:
- `DATA_W`, default 32: width of activations and weights; matches the array's 32-bit datapath.
- `DRAIN_CYCLES`, default 3: cycles `compute` stays high after the last activation, so partial sums can propagate south.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `wr_en`, input, 1: buffer write strobe.
- `wr_sel`, input, 1: 0 selects the activation buffer, 1 selects the weight buffer.
- `wr_addr`, input, 4: row-major index 0..8; 9..15 are ignored.
- `wr_data`, input, `DATA_W`: write data.
- `wr_ready`, output, 1: high only in IDLE; writes with `wr_ready`=0 are dropped.
- `start`, input, 1: single-cycle run request.
- `busy`, output, 1: high in every non-IDLE state.
- `done`, output, 1: one-cycle pulse at the end of a run.
- `west0`, `west3`, `west6`, output, `DATA_W` each: skewed activations for array rows 0, 1, 2.
- `weight0`..`weight8`, output, `DATA_W` each: weight tile, row-major.
- `compute`, output, 1: array compute enable.
- `weight_en`, output, 1: array weight-load enable.

## Operation
- Buffers: `A[r][k]` is activation for array row r at step k, stored at `wr_addr` = 3r+k. `W[i]` is stored at `wr_addr` = i.
- `weight0..8` always show `W[0..8]` combinationally from the weight registers.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE -> LOAD_W when `start`=1. If `start` and `wr_en` are both high in IDLE, the write completes first; the run uses the new value.
- LOAD_W: lasts 1 cycle with `weight_en`=1, then goes to STREAM.
- STREAM: stream counter t runs 0..4 (5 cycles) with `compute`=1. `west_r` = `A[r][t-r]` when 0 ≤ t-r ≤ 2, else 0.
  - Row 0 sees A00, A01, A02, 0, 0.
  - Row 1 sees 0, A10, A11, A12, 0.
  - Row 2 sees 0, 0, A20, A21, A22.
- DRAIN: lasts `DRAIN_CYCLES` cycles with `compute`=1 and all west outputs 0. If `DRAIN_CYCLES`=0, DRAIN is skipped.
- DONE: lasts 1 cycle with `done`=1 and `compute`=0, then returns to IDLE.
- `start` is ignored outside IDLE. Buffers are read-only while `busy`=1.
- Reset values:
  - State is IDLE and all buffer entries are 0.
  - `west*`=0, `weight*`=0, `compute`=0, `weight_en`=0, `busy`=0, `done`=0, `wr_ready`=1.
- Reset mid-run: on the next edge the FSM is in IDLE, all outputs take reset values, and buffers are cleared. No `done` is produced.

## Timing
- Let E0 be the edge that samples `start` in IDLE.
- After E0: LOAD_W, with `weight_en`=1 and `busy`=1.
- After E0+1 through E0+5: STREAM t=0..4. `west*` are registered and valid the same cycle as `compute`.
- After E0+6 through E0+5+`DRAIN_CYCLES`: DRAIN.
- Next cycle: DONE with `done`=1. With the default `DRAIN_CYCLES`, `done` is high in cycle 10 after E0.
- The cycle after DONE: IDLE, with `wr_ready`=1. A `start` sampled in that cycle begins a new run with no gap.
- `weight_en` and `compute` are never high in the same cycle.

## Configuration
- Macro: `SYSTOLIC_FEEDER_WEIGHT_REUSE_EN`.
- When defined:
  - A dirty flag is set by any accepted weight write and by reset, and cleared on leaving LOAD_W.
  - On `start` with the flag clear, IDLE goes directly to STREAM. There is no `weight_en` pulse, and the run is 1 cycle shorter (`done` in cycle 9 after E0).
- When not defined: every run passes through LOAD_W.

## Test plan
- Reset, then check outputs: all outputs 0, `wr_ready`=1, `busy`=0.
- Write A = 1..9 and W = 10..18, pulse `start`:
  - `weight_en` pulses once with `weight0..8` = 10..18.
  - `west0` = 1,2,3,0,0; `west3` = 0,4,5,6,0; `west6` = 0,0,7,8,9.
  - `compute` is high for 8 cycles; `done` is high in cycle 10.
- Writes and `start` while busy:
  - A write of 99 to `A[0]` while busy is dropped; the next run's `west0` starts with 1.
  - A second `start` pulse while busy produces no extra run.
- Assert `rst` during STREAM t=2: next cycle all outputs are 0 and state is IDLE. A following run with no new writes shows all west values 0.
- Back-to-back: `start` in the cycle after `done` gives a second identical sequence, with no idle gap beyond the DONE cycle.
- With `SYSTOLIC_FEEDER_WEIGHT_REUSE_EN`:
  - Second `start` with no weight write: no `weight_en`, `done` in cycle 9.
  - Then write W[4]=7 and start again: `weight_en` pulses with `weight4`=7.
